// File: rtl/adder_pkg.sv
// Shared constants and the golden add function for the registered adder.
package adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned MAX_WIDTH     = 32;

  // Full-width reference sum {carry, sum} of a + b + cin.
  // Operands are zero-extended to MAX_WIDTH, so callers pass narrower values cast up.
  function automatic logic [MAX_WIDTH:0] ref_add(
    input logic [MAX_WIDTH-1:0] a,
    input logic [MAX_WIDTH-1:0] b,
    input logic                 cin
  );
    return {1'b0, a} + {1'b0, b} + {{MAX_WIDTH{1'b0}}, cin};
  endfunction

endpackage : adder_pkg

// File: rtl/adder_4_reg_full_adder_1b.sv
// One-bit full adder cell; the ripple chain in the top level is built from these.
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  // Propagate term is shared by the sum and the carry.
  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule : full_adder_1b

// File: rtl/adder_4_reg.sv
// WIDTH-bit ripple-carry adder with carry-in/out and one registered output stage.
module adder_4_reg
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] SUM,
  output logic             Cout,
  output logic             out_valid
);

  // carry[i] feeds bit i; carry[0] is the external carry-in, carry[WIDTH] is the carry-out.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_bits;
  logic [WIDTH:0]   sum_full;

  assign carry[0] = Cin;

  // Ripple chain: each cell consumes the carry of the cell below it.
  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    full_adder_1b u_fa (
      .a  (A[i]),
      .b  (B[i]),
      .ci (carry[i]),
      .s  (sum_bits[i]),
      .co (carry[i+1])
    );
  end

  assign sum_full = {carry[WIDTH], sum_bits};

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             valid_q, valid_d;

  // Next-state: capture the new sum on a valid input, otherwise hold; out_valid pulses only on capture.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    sum_d   = sum_q;
    cout_d  = cout_q;
    valid_d = 1'b0;
    if (in_valid) begin
      sum_d   = sum_full[WIDTH-1:0];
      cout_d  = sum_full[WIDTH];
      valid_d = 1'b1;
    end
  end

  // Output registers with synchronous reset taking priority over a captured add.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end

  assign SUM       = sum_q;
  assign Cout      = cout_q;
  assign out_valid = valid_q;

  // The ripple chain must always agree with the plain-arithmetic golden sum.
  logic [MAX_WIDTH:0] ref_full;
  assign ref_full = ref_add(MAX_WIDTH'(A), MAX_WIDTH'(B), Cin);

  a_ripple_matches_ref : assert property (
    @(posedge clk) disable iff (rst) ((MAX_WIDTH+1)'(sum_full) == ref_full)
  );

endmodule : adder_4_reg

// File: tb/tb_adder_4_reg.sv
// Self-checking bench: a WIDTH=4 instance for directed and exhaustive tests, a WIDTH=8 instance for random vectors.
module tb_adder_4_reg;

  logic clk = 1'b0;
  logic rst;

  logic       iv4, c4, co4, ov4;
  logic [3:0] a4, b4, s4;

  logic       iv8, c8, co8, ov8;
  logic [7:0] a8, b8, s8;

  int checks = 0;
  int errors = 0;

  // Reference model state: what each output should show after the latest edge.
  int m4_sum = 0, m4_cout = 0, m4_ov = 0;
  int m8_sum = 0, m8_cout = 0, m8_ov = 0;

  always #5 clk = ~clk;

  adder_4_reg #(.WIDTH(4)) dut4 (
    .clk (clk), .rst (rst), .in_valid (iv4),
    .A (a4), .B (b4), .Cin (c4),
    .SUM (s4), .Cout (co4), .out_valid (ov4)
  );

  adder_4_reg #(.WIDTH(8)) dut8 (
    .clk (clk), .rst (rst), .in_valid (iv8),
    .A (a8), .B (b8), .Cin (c8),
    .SUM (s8), .Cout (co8), .out_valid (ov8)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive4(input logic iv, input logic [3:0] a, input logic [3:0] b, input logic c);
    iv4 = iv; a4 = a; b4 = b; c4 = c;
  endtask

  task automatic drive8(input logic iv, input logic [7:0] a, input logic [7:0] b, input logic c);
    iv8 = iv; a8 = a; b8 = b; c8 = c;
  endtask

  // Advance the model from the current inputs, then clock and settle just past the edge.
  task automatic cycle();
    int t;
    if (rst) begin
      m4_sum = 0; m4_cout = 0; m4_ov = 0;
      m8_sum = 0; m8_cout = 0; m8_ov = 0;
    end else begin
      if (iv4) begin
        t = int'(a4) + int'(b4) + int'(c4);
        m4_sum = t % 16; m4_cout = t / 16; m4_ov = 1;
      end else m4_ov = 0;
      if (iv8) begin
        t = int'(a8) + int'(b8) + int'(c8);
        m8_sum = t % 256; m8_cout = t / 256; m8_ov = 1;
      end else m8_ov = 0;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] obs4();
    return 16'({ov4, co4, s4});
  endfunction

  function automatic logic [15:0] obs8();
    return 16'({ov8, co8, s8});
  endfunction

  function automatic logic [15:0] exp4(input logic ov, input logic co, input logic [3:0] s);
    return 16'({ov, co, s});
  endfunction

  function automatic logic [15:0] mdl4();
    return 16'(m4_ov * 32 + m4_cout * 16 + m4_sum);
  endfunction

  function automatic logic [15:0] mdl8();
    return 16'(m8_ov * 512 + m8_cout * 256 + m8_sum);
  endfunction

  initial begin
    rst = 1'b1;
    drive4(1'b1, 4'($urandom), 4'($urandom), 1'($urandom));
    drive8(1'b0, '0, '0, 1'b0);

    // Reset held for two cycles with live random inputs.
    for (int i = 0; i < 2; i++) begin
      drive4(1'b1, 4'($urandom), 4'($urandom), 1'($urandom));
      cycle();
      check("reset4", obs4(), exp4(1'b0, 1'b0, 4'd0));
      check("reset8", obs8(), 16'd0);
    end

    rst = 1'b0;
    drive4(1'b1, 4'd11, 4'd4, 1'b0);
    cycle();
    check("first_11_4", obs4(), exp4(1'b1, 1'b0, 4'd15));

    // Back-to-back carry-out cases, Cin=0.
    drive4(1'b1, 4'd8, 4'd12, 1'b0);  cycle(); check("b2b_8_12",   obs4(), exp4(1'b1, 1'b1, 4'd4));
    drive4(1'b1, 4'd2, 4'd1, 1'b0);   cycle(); check("b2b_2_1",    obs4(), exp4(1'b1, 1'b0, 4'd3));
    drive4(1'b1, 4'd14, 4'd15, 1'b0); cycle(); check("b2b_14_15",  obs4(), exp4(1'b1, 1'b1, 4'd13));
    drive4(1'b1, 4'd11, 4'd11, 1'b0); cycle(); check("b2b_11_11",  obs4(), exp4(1'b1, 1'b1, 4'd6));

    // Carry-in, maximum, and full-ripple cases.
    drive4(1'b1, 4'd2, 4'd1, 1'b1);   cycle(); check("cin_2_1",    obs4(), exp4(1'b1, 1'b0, 4'd4));
    drive4(1'b1, 4'd15, 4'd15, 1'b1); cycle(); check("cin_max",    obs4(), exp4(1'b1, 1'b1, 4'd15));
    drive4(1'b1, 4'd15, 4'd0, 1'b1);  cycle(); check("cin_ripple", obs4(), exp4(1'b1, 1'b1, 4'd0));
    drive4(1'b1, 4'd0, 4'd0, 1'b0);   cycle(); check("zero",       obs4(), exp4(1'b1, 1'b0, 4'd0));

    // Hold: produce 6/1, then drop in_valid while inputs keep changing.
    drive4(1'b1, 4'd11, 4'd11, 1'b0); cycle(); check("hold_setup", obs4(), exp4(1'b1, 1'b1, 4'd6));
    for (int i = 0; i < 3; i++) begin
      drive4(1'b0, 4'($urandom), 4'($urandom), 1'($urandom));
      cycle();
      check("hold", obs4(), exp4(1'b0, 1'b1, 4'd6));
    end

    // Reset wins over a valid add on the same edge.
    rst = 1'b1;
    drive4(1'b1, 4'd9, 4'd9, 1'b0);
    cycle();
    check("rst_priority", obs4(), exp4(1'b0, 1'b0, 4'd0));
    rst = 1'b0;
    drive4(1'b0, 4'd0, 4'd0, 1'b0);
    cycle();
    check("post_rst_idle", obs4(), exp4(1'b0, 1'b0, 4'd0));

    // Exhaustive WIDTH=4 sweep, back-to-back.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) begin
          drive4(1'b1, 4'(a), 4'(b), 1'(c));
          cycle();
          check("sweep4", obs4(), mdl4());
        end

    // Random WIDTH=8 vectors with occasional idle cycles to exercise hold.
    drive4(1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 10000; i++) begin
      drive8(($urandom_range(7) != 0), 8'($urandom), 8'($urandom), 1'($urandom));
      cycle();
      check("rand8", obs8(), mdl8());
    end

    // WIDTH=8 extremes.
    drive8(1'b1, 8'hFF, 8'hFF, 1'b1); cycle(); check("max8",  obs8(), 16'h3FF);
    drive8(1'b1, 8'hFF, 8'h00, 1'b1); cycle(); check("wrap8", obs8(), 16'h300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_adder_4_reg
